// File: rtl/shift_mix_if.sv
// Word bundle between the SubBytes stage, the ShiftRows/MixColumns stage and AddRoundKey.
// valid/ready: a word moves on a rising edge where valid=1 and ready=1; the producer holds it stable while valid=1 and ready=0.
interface shift_mix_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_last;
    logic [3:0]   in_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_last;
    logic [3:0]   out_round;

    modport master (
        output in_valid, in_state, in_last, in_round, out_ready,
        input  in_ready, out_valid, out_state, out_last, out_round
    );

    modport slave (
        input  in_valid, in_state, in_last, in_round, out_ready,
        output in_ready, out_valid, out_state, out_last, out_round
    );
endinterface

// File: rtl/shift_mix_stage.sv
// AES ShiftRows + MixColumns (bypassed on the final round) feeding a 2-entry skid FIFO.
// The transform is computed on the input side so storage only holds finished words.
module shift_mix_stage (
    input  logic       clk,
    input  logic       rst,
    shift_mix_if.slave bus
);
    typedef struct packed {
        logic [127:0] state;
        logic         last;
        logic [3:0]   round;
    } entry_t;

    entry_t       mem0_q, mem0_d, mem1_q, mem1_d;
    entry_t       head;
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         accept, pop;
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] result;

    function automatic logic [7:0] x2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] x3(input logic [7:0] a);
        return x2(a) ^ a;
    endfunction

    // Byte k is s[k%4][k/4]; ShiftRows rotates row r left by r columns.
    for (genvar k = 0; k < 16; k++) begin : g_bytes
        assign sb[k] = bus.in_state[127-8*k -: 8];
        assign result[127-8*k -: 8] = bus.in_last ? sr[k] : mc[k];
    end

    for (genvar c = 0; c < 4; c++) begin : g_cols
        for (genvar r = 0; r < 4; r++) begin : g_rows
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
        end
        assign mc[4*c+0] = x2(sr[4*c+0]) ^ x3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c+0] ^ x2(sr[4*c+1]) ^ x3(sr[4*c+2]) ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ x2(sr[4*c+2]) ^ x3(sr[4*c+3]);
        assign mc[4*c+3] = x3(sr[4*c+0]) ^ sr[4*c+1] ^ sr[4*c+2] ^ x2(sr[4*c+3]);
    end

    // in_ready depends only on the registered count, never on out_ready.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_ready & bus.out_valid;

    assign head          = rd_ptr_q ? mem1_q : mem0_q;
    assign bus.out_state = head.state;
    assign bus.out_last  = head.last;
    assign bus.out_round = head.round;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            if (wr_ptr_q) begin
                mem1_d = '{state: result, last: bus.in_last, round: bus.in_round};
            end else begin
                mem0_d = '{state: result, last: bus.in_last, round: bus.in_round};
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: doc/shift_mix_stage.md
SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream (SubBytes result) word valid.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_state  input  128  post-SubBytes AES state.
REQ-007 in_last  input  1  final round: bypass MixColumns.
REQ-008 in_round  input  4  round tag, passed through unmodified.
REQ-009 out_valid  output  1  output word valid.
REQ-010 out_ready  input  1  downstream (AddRoundKey) can accept.
REQ-011 out_state  output  128  ShiftRows(+MixColumns) result.
REQ-012 out_last  output  1  in_last of the word on out_state.
REQ-013 out_round  output  4  in_round of the word on out_state.

Function
REQ-014 Byte k (k=0..15) SHALL be state[127-8k -: 8]; byte k is AES state element s[r][c] with r=k mod 4, c=k/4.
REQ-015 ShiftRows SHALL set s'[r][c] = s[r][(c+r) mod 4].
REQ-016 MixColumns SHALL apply per column the FIPS-197 matrix {02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02} over GF(2^8), reduction polynomial 0x11B (xtime: shift left, XOR 0x1B on bit-7 carry).
REQ-017 When in_last=1 the stored result SHALL be ShiftRows only; when 0, MixColumns(ShiftRows(in_state)).
REQ-018 Transformation SHALL be computed on the input side; storage holds {result, last, round}.
REQ-019 Storage SHALL be a 2-entry FIFO with 2-bit count (0..2), read and write pointers.
REQ-020 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-021 in_ready SHALL be 1 exactly when count<2, derived from registered count only (no combinational path from out_ready).
REQ-022 out_valid SHALL be 1 exactly when count>0; out_state/out_last/out_round SHALL show the entry at the read pointer.
REQ-023 Latency: a word accepted at edge N SHALL appear on the outputs from edge N onward when the FIFO was empty (one cycle from acceptance).
REQ-024 Count transitions: accept only +1; pop only -1; accept and pop in the same cycle leaves count unchanged and both pointers advance.
REQ-025 Pointers SHALL wrap 1->0.
REQ-026 Full (count=2): in_ready=0; in_valid ignored, no overwrite.
REQ-027 Empty (count=0): out_ready ignored, count does not underflow.
REQ-028 While out_valid=1 and out_ready=0, out_state/out_last/out_round SHALL hold stable.
REQ-029 Words SHALL leave in acceptance order; no loss or duplication.
REQ-030 Sustained in_valid=1 and out_ready=1 SHALL give one word per cycle.

Reset
REQ-031 While rst=1 at a clock edge: count=0, both pointers=0, so out_valid=0 and in_ready=1 from the next cycle.
REQ-032 Reset mid-operation SHALL discard all stored words; no word accepted in the reset cycle is retained.
REQ-033 out_state, out_last, out_round SHALL read 0 after reset until the first accept (storage cleared).

Verification
REQ-034 Mix round: in_state=128'hd42711aee0bf98f1b8b45de51e415230, in_last=0, in_round=1, out_ready=1 -> next cycle out_valid=1, out_state=128'h046681e5e0cb199a48f8d37a2806264c, out_round=1, out_last=0.
REQ-035 Final round: same in_state, in_last=1, in_round=10 -> out_state=128'hd4bf5d30e0b452aeb84111f11e2798e5, out_last=1, out_round=10.
REQ-036 Backpressure: out_ready=0, three back-to-back words A,B,C offered -> A,B accepted, in_ready=0 after 2nd accept, C stalls; out_state=A stable; then out_ready=1 -> A,B,C emerge in order, one per cycle.
REQ-037 Streaming: 16 consecutive words, in_valid=1, out_ready=1 throughout -> 16 outputs on 16 consecutive cycles, in_ready never 0, count stays at 1.
REQ-038 Reset mid-stream: count=2, rst=1 for one edge -> out_valid=0, in_ready=1, out_state=0 next cycle; stored words never appear.
REQ-039 Random in_valid/out_ready (10k words) against a reference ShiftRows/MixColumns model -> all outputs match in order, REQ-028 holds every stall cycle.
